// File: rtl/cb_crc24b_attach_if.sv
// Byte-stream interface between the code-block segmenter, the CRC-24B
// attach stage and the turbo-encoder input stage.
interface cb_crc24b_attach_if;
    logic       in_start;
    logic       in_size;
    logic [7:0] in_data;
    logic       in_filling;
    logic       in_crc;
    logic       out_start;
    logic       out_size;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       protocol_err;

    modport master (
        output in_start, in_size, in_data, in_filling, in_crc,
        input  out_start, out_size, out_valid, out_data, out_last, protocol_err
    );

    modport slave (
        input  in_start, in_size, in_data, in_filling, in_crc,
        output out_start, out_size, out_valid, out_data, out_last, protocol_err
    );
endinterface

// File: rtl/cb_crc24b_attach.sv
// CRC-24B attach: folds each code block's payload into a bit-serial CRC-24B
// and replaces the three trailing CRC slots with the result, one cycle later.
//
// state | meaning
// IDLE  | waiting for in_start
// DATA  | folding payload bytes into the CRC, counter tracks bytes left
// CRC   | emitting the three CRC bytes in place of the slot bytes
module cb_crc24b_attach #(
    parameter int          LARGE_BYTES = 768,
    parameter int          SMALL_BYTES = 132,
    parameter logic [23:0] CRC_POLY    = 24'h800063
) (
    input logic               clk,
    input logic               reset,
    cb_crc24b_attach_if.slave bus
);
    localparam int CW = $clog2(LARGE_BYTES);
    localparam logic [CW-1:0] LOAD_L = CW'(LARGE_BYTES - 1);
    localparam logic [CW-1:0] LOAD_S = CW'(SMALL_BYTES - 1);
    localparam logic [CW-1:0] CNT_3  = CW'(3);
    localparam logic [CW-1:0] CNT_2  = CW'(2);
    localparam logic [CW-1:0] CNT_1  = CW'(1);

    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;

    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n, cnt_dec;
    logic [23:0]   crc_q, crc_n;
    logic          size_q, size_n;
    logic          err_q, err_n;
    logic [7:0]    byte_in;

    logic          vld_q, vld_n;
    logic          sop_q, sop_n;
    logic          eop_q, eop_n;
    logic          osz_q, osz_n;
    logic [7:0]    dat_q, dat_n;

    // Eight MSB-first shifts of the CRC-24B LFSR.
    function automatic logic [23:0] crc_fold(input logic [23:0] c_in, input logic [7:0] d);
        logic [23:0] c;
        logic        fb;
        c = c_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[23] ^ d[i];
            c  = {c[22:0], 1'b0} ^ (fb ? CRC_POLY : 24'd0);
        end
        return c;
    endfunction

    // Next-state, CRC update, violation tracking and next output values.
    always_comb begin
        state_n = state_q;
        cnt_n   = cnt_q;
        crc_n   = crc_q;
        size_n  = size_q;
        err_n   = err_q;
        vld_n   = 1'b0;
        sop_n   = 1'b0;
        eop_n   = 1'b0;
        osz_n   = 1'b0;
        dat_n   = 8'h00;
        byte_in = bus.in_filling ? 8'h00 : bus.in_data;
        cnt_dec = cnt_q - CNT_1;

        if (bus.in_start) begin
            // A start outside IDLE aborts the block and flags it; a clean
            // start in IDLE clears the sticky flag. Byte 0 is never a slot.
            err_n   = (state_q != IDLE) || bus.in_crc;
            size_n  = bus.in_size;
            cnt_n   = bus.in_size ? LOAD_L : LOAD_S;
            crc_n   = crc_fold(24'd0, byte_in);
            state_n = DATA;
            vld_n   = 1'b1;
            sop_n   = 1'b1;
            dat_n   = byte_in;
            osz_n   = bus.in_size;
        end else begin
            case (state_q)
                DATA: begin
                    crc_n = crc_fold(crc_q, byte_in);
                    cnt_n = cnt_dec;
                    if (cnt_dec == CNT_3) state_n = CRC;
                    vld_n = 1'b1;
                    dat_n = byte_in;
                    osz_n = size_q;
                    if (bus.in_crc) err_n = 1'b1;
                end
                CRC: begin
                    cnt_n = cnt_dec;
                    vld_n = 1'b1;
                    osz_n = size_q;
                    if (cnt_q == CNT_3)      dat_n = crc_q[23:16];
                    else if (cnt_q == CNT_2) dat_n = crc_q[15:8];
                    else                     dat_n = crc_q[7:0];
                    if (cnt_q == CNT_1) begin
                        eop_n   = 1'b1;
                        state_n = IDLE;
                    end
                    if (!bus.in_crc) err_n = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, counter, CRC and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            crc_q   <= 24'd0;
            size_q  <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            osz_q   <= 1'b0;
            dat_q   <= 8'h00;
        end else begin
            state_q <= state_n;
            cnt_q   <= cnt_n;
            crc_q   <= crc_n;
            size_q  <= size_n;
            err_q   <= err_n;
            vld_q   <= vld_n;
            sop_q   <= sop_n;
            eop_q   <= eop_n;
            osz_q   <= osz_n;
            dat_q   <= dat_n;
        end
    end

    assign bus.out_start    = sop_q;
    assign bus.out_size     = osz_q;
    assign bus.out_valid    = vld_q;
    assign bus.out_data     = dat_q;
    assign bus.out_last     = eop_q;
    assign bus.protocol_err = err_q;
endmodule

// File: tb/tb_cb_crc24b_attach.sv
// Bench for cb_crc24b_attach: drives code blocks, captures the output stream
// and compares it with a polynomial long-division reference.
module tb_cb_crc24b_attach;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;

    cb_crc24b_attach_if bus ();

    cb_crc24b_attach dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] pay [768];
    bit         fill[768];

    logic [7:0] od[$];
    bit         ost[$], ola[$], osz[$];
    int         ocy[$];
    logic [7:0] ed[$];
    bit         es[$], el[$], ez[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output byte together with its flags and cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            od.push_back(bus.out_data);
            ost.push_back(bus.out_start);
            ola.push_back(bus.out_last);
            osz.push_back(bus.out_size);
            ocy.push_back(cyc);
        end
    end

    // Remainder of payload(x) * x^24 divided by the CRC-24B generator.
    function automatic logic [23:0] ref_crc(input int npay);
        bit          msg[6144];
        logic [24:0] g;
        logic [23:0] r;
        g = 25'h1800063;
        foreach (msg[k]) msg[k] = 1'b0;
        for (int i = 0; i < npay; i++)
            for (int b = 0; b < 8; b++)
                msg[i*8+b] = fill[i] ? 1'b0 : pay[i][7-b];
        for (int i = 0; i < npay*8; i++)
            if (msg[i])
                for (int j = 0; j < 25; j++) msg[i+j] ^= g[24-j];
        for (int j = 0; j < 24; j++) r[23-j] = msg[npay*8+j];
        return r;
    endfunction

    // Append the first nbytes of the expected output for the current payload.
    function automatic void expect_block(input bit big, input int nbytes);
        int          n;
        logic [23:0] c;
        n = big ? 768 : 132;
        c = ref_crc(n - 3);
        for (int i = 0; i < nbytes; i++) begin
            if (i < n - 3)       ed.push_back(fill[i] ? 8'h00 : pay[i]);
            else if (i == n - 3) ed.push_back(c[23:16]);
            else if (i == n - 2) ed.push_back(c[15:8]);
            else                 ed.push_back(c[7:0]);
            es.push_back(i == 0);
            el.push_back(i == n - 1);
            ez.push_back(big);
        end
    endfunction

    task automatic set_payload(input bit rnd, input int fill_one_in);
        for (int i = 0; i < 768; i++) begin
            pay[i]  = rnd ? 8'($urandom) : 8'h00;
            fill[i] = (fill_one_in > 0) ? ($urandom_range(fill_one_in - 1) == 0) : 1'b0;
        end
    endtask

    task automatic clear_all();
        od.delete(); ost.delete(); ola.delete(); osz.delete(); ocy.delete();
        ed.delete(); es.delete(); el.delete(); ez.delete();
    endtask

    task automatic drive_block(input bit big, input int nbytes, input int bad_idx);
        int n;
        n = big ? 768 : 132;
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            bus.in_start   = (i == 0);
            bus.in_size    = (i == 0) ? big : 1'($urandom);
            bus.in_data    = (i < n - 3) ? pay[i] : 8'($urandom);
            bus.in_filling = (i < n - 3) ? fill[i] : 1'b0;
            bus.in_crc     = (i >= n - 3) ^ (i == bad_idx);
        end
    endtask

    task automatic drive_idle(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            bus.in_start   = 1'b0;
            bus.in_size    = 1'b0;
            bus.in_data    = 8'($urandom);
            bus.in_filling = 1'b0;
            bus.in_crc     = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_idle(3);
        checks++;
        if ({bus.out_start, bus.out_size, bus.out_valid, bus.out_last, bus.protocol_err} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {bus.out_start, bus.out_size, bus.out_valid, bus.out_last, bus.protocol_err});
        end
        checks++;
        if (bus.out_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got %h exp 00", bus.out_data);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        drive_idle(2);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_valid got %b exp 0", bus.out_valid);
        end
    endtask

    task automatic test_small_zero();
        clear_all();
        set_payload(1'b0, 0);
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        drive_idle(4);
        checks++;
        if (od.size() != ed.size()) begin
            errors++;
            $display("FAIL small_zero_len got %0d exp %0d", od.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL small_zero_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
        checks++;
        if (od.size() == 132 && {od[129], od[130], od[131], ola[131]} !== {24'h000000, 1'b1}) begin
            errors++;
            $display("FAIL small_zero_crc got %h%h%h last=%b exp 000000 last=1",
                     od[129], od[130], od[131], ola[131]);
        end
        checks++;
        if (bus.protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL small_zero_err got %b exp 0", bus.protocol_err);
        end
    endtask

    task automatic test_small_one();
        clear_all();
        set_payload(1'b0, 0);
        pay[128] = 8'h01;
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        drive_idle(4);
        checks++;
        if (od.size() != ed.size()) begin
            errors++;
            $display("FAIL small_one_len got %0d exp %0d", od.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL small_one_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
        checks++;
        if (od.size() == 132 && {od[129], od[130], od[131]} !== 24'h800063) begin
            errors++;
            $display("FAIL small_one_crc got %h%h%h exp 800063", od[129], od[130], od[131]);
        end
    endtask

    task automatic test_large_filler();
        clear_all();
        set_payload(1'b0, 0);
        for (int i = 0; i < 8; i++) begin
            pay[i]  = 8'hFF;
            fill[i] = 1'b1;
        end
        pay[764] = 8'h01;
        expect_block(1'b1, 768);
        drive_block(1'b1, 768, -1);
        drive_idle(4);
        checks++;
        if (od.size() != 768 || (ocy[od.size()-1] - ocy[0]) != 767) begin
            errors++;
            $display("FAIL large_valid_run got %0d bytes exp 768 contiguous", od.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL large_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
        checks++;
        if (od.size() == 768 && {od[765], od[766], od[767]} !== 24'h800063) begin
            errors++;
            $display("FAIL large_crc got %h%h%h exp 800063", od[765], od[766], od[767]);
        end
    endtask

    task automatic test_back_to_back();
        clear_all();
        set_payload(1'b1, 6);
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        set_payload(1'b1, 6);
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        drive_idle(4);
        checks++;
        if (od.size() != 264 || (ocy[od.size()-1] - ocy[0]) != 263) begin
            errors++;
            $display("FAIL b2b_valid_run got %0d bytes exp 264 contiguous", od.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL b2b_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
    endtask

    task automatic test_abort();
        clear_all();
        set_payload(1'b1, 0);
        expect_block(1'b0, 50);
        el[49] = 1'b0;
        drive_block(1'b0, 50, -1);
        set_payload(1'b1, 0);
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        drive_idle(4);
        checks++;
        if (od.size() != ed.size()) begin
            errors++;
            $display("FAIL abort_len got %0d exp %0d", od.size(), ed.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL abort_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
        checks++;
        if (bus.protocol_err !== 1'b1) begin
            errors++;
            $display("FAIL abort_err_set got %b exp 1", bus.protocol_err);
        end
        set_payload(1'b1, 0);
        drive_block(1'b0, 132, -1);
        drive_idle(3);
        checks++;
        if (bus.protocol_err !== 1'b0) begin
            errors++;
            $display("FAIL abort_err_clear got %b exp 0", bus.protocol_err);
        end
    endtask

    task automatic test_crc_flag();
        int bad[2];
        bad[0] = 10;
        bad[1] = 130;
        foreach (bad[k]) begin
            clear_all();
            set_payload(1'b1, 5);
            expect_block(1'b0, 132);
            drive_block(1'b0, 132, bad[k]);
            drive_idle(3);
            checks++;
            if (bus.protocol_err !== 1'b1) begin
                errors++;
                $display("FAIL crcflag%0d_err got %b exp 1", bad[k], bus.protocol_err);
            end
            checks++;
            if (od.size() != 132 || {od[129], od[130], od[131]} !== {ed[129], ed[130], ed[131]}) begin
                errors++;
                $display("FAIL crcflag%0d_crc got %0d bytes exp crc %h%h%h",
                         bad[k], od.size(), ed[129], ed[130], ed[131]);
            end
        end
    endtask

    task automatic test_random();
        bit big;
        for (int t = 0; t < 5; t++) begin
            clear_all();
            big = ($urandom_range(3) == 0);
            set_payload(1'b1, 8);
            expect_block(big, big ? 768 : 132);
            drive_block(big, big ? 768 : 132, -1);
            drive_idle($urandom_range(4, 1));
            drive_idle(3);
            checks++;
            if (od.size() != ed.size()) begin
                errors++;
                $display("FAIL rand%0d_len got %0d exp %0d", t, od.size(), ed.size());
            end
            for (int i = 0; i < ed.size() && i < od.size(); i++) begin
                checks++;
                if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                    errors++;
                    $display("FAIL rand%0d_b%0d got %h/%b%b%b exp %h/%b%b%b",
                             t, i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        set_payload(1'b1, 0);
        drive_block(1'b1, 300, -1);
        @(posedge clk); #1;
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_valid got %b exp 1", bus.out_valid);
        end
        reset = 1'b1;
        bus.in_start = 1'b1;
        #1;
        checks++;
        if ({bus.out_start, bus.out_size, bus.out_valid, bus.out_last, bus.protocol_err, bus.out_data} !== 13'd0) begin
            errors++;
            $display("FAIL midreset_outputs got %b exp 0",
                     {bus.out_start, bus.out_size, bus.out_valid, bus.out_last, bus.protocol_err, bus.out_data});
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.in_start = 1'b0;
        reset = 1'b0;
        clear_all();
        drive_idle(2);
        set_payload(1'b0, 0);
        expect_block(1'b0, 132);
        drive_block(1'b0, 132, -1);
        drive_idle(4);
        checks++;
        if (od.size() != 132) begin
            errors++;
            $display("FAIL midreset_len got %0d exp 132", od.size());
        end
        for (int i = 0; i < ed.size() && i < od.size(); i++) begin
            checks++;
            if ({od[i], ost[i], ola[i], osz[i]} !== {ed[i], es[i], el[i], ez[i]}) begin
                errors++;
                $display("FAIL midreset_b%0d got %h/%b%b%b exp %h/%b%b%b",
                         i, od[i], ost[i], ola[i], osz[i], ed[i], es[i], el[i], ez[i]);
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        bus.in_start   = 1'b0;
        bus.in_size    = 1'b0;
        bus.in_data    = 8'h00;
        bus.in_filling = 1'b0;
        bus.in_crc     = 1'b0;
        test_reset();
        test_small_zero();
        test_small_one();
        test_large_filler();
        test_back_to_back();
        test_abort();
        test_crc_flag();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
